rr_arb_4_to_1: RTL and testbench

//  Four-channel round-robin arbiter. It merges four valid/ready input streams

---
 rtl/rr_arb_pkg.sv | 10 +
 rtl/rr_arb_4_to_1_mux_4_1.sv | 23 ++
 rtl/rr_arb_4_to_1.sv | 93 +++++++++
 tb/tb_rr_arb_4_to_1.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-channel round-robin arbiter.
package rr_arb_pkg;
  localparam int N_CH = 4;

  typedef logic [1:0] ch_idx_t;

  function automatic ch_idx_t next_idx(input ch_idx_t idx);
    return idx + 2'd1;
  endfunction
endpackage

// File: rtl/rr_arb_4_to_1_mux_4_1.sv
// Purely combinational 4:1 data mux; zero latency; no flow control.
// Unselected inputs never reach y, so X on an idle channel is harmless.
module mux_4_1 #(
  parameter int W = 4
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);
  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end
endmodule

// File: rtl/rr_arb_4_to_1.sv
// Round-robin merge of four valid/ready streams into one registered output; 1-cycle latency.
// Output register holds under out_ready=0 and in_ready drops to zero until it drains.
module rr_arb_4_to_1
  import rr_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_src
);
  generate
    if (W != 4) begin : g_bad_width
      $error("rr_arb_4_to_1: only W=4 is supported");
    end
  endgenerate

  ch_idx_t        r_ptr;
  logic           r_out_valid;
  logic [W-1:0]   r_out_data;
  ch_idx_t        r_out_src;

  ch_idx_t        w_gnt_idx;
  logic           w_any_req;
  logic           w_load;
  logic           w_take;
  logic [W-1:0]   w_mux_y;

  // Priority search starting at r_ptr, wrapping 3->0.
  always_comb begin
    ch_idx_t cand;
    logic    found;
    w_gnt_idx = r_ptr;
    found     = 1'b0;
    cand      = r_ptr;
    for (int k = 0; k < N_CH; k++) begin
      cand = r_ptr + ch_idx_t'(k);
      if (!found && in_valid[cand]) begin
        w_gnt_idx = cand;
        found     = 1'b1;
      end
    end
  end

  assign w_any_req = |in_valid;
  assign w_load    = ~r_out_valid | out_ready;
  assign w_take    = w_load & w_any_req & ~rst;

  always_comb begin
    in_ready = 4'b0000;
    if (w_take) in_ready[w_gnt_idx] = 1'b1;
  end

  mux_4_1 #(.W(W)) u_mux (
    .sel (w_gnt_idx),
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .y   (w_mux_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_load) begin
      if (w_any_req) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_y;
        r_out_src   <= w_gnt_idx;
        r_ptr       <= next_idx(w_gnt_idx);
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
endmodule

// File: tb/tb_rr_arb_4_to_1.sv
// Directed bench for rr_arb_4_to_1: one task per scenario with inline checks.
module tb_rr_arb_4_to_1;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [3:0] d0, d1, d2, d3;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_src;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_arb_4_to_1 #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  // Inputs change 1 time unit after posedge; outputs are read 2 units after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 4'h0; out_ready = 1'b1;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      n_cmp++;
      if ({out_valid, out_data, out_src} !== 7'b0) begin
        n_bad++;
        $display("FAIL reset_out cyc%0d: got v=%b d=%h s=%0d, want 0/0/0", c, out_valid, out_data, out_src);
      end
      n_cmp++;
      if (in_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_in_ready cyc%0d: got %b, want 0000", c, in_ready);
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_first_gnt_rdy: got %b, want 0001", in_ready);
    end
    tick(); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 4'h1) begin
      n_bad++;
      $display("FAIL reset_first_gnt: got v=%b s=%0d d=%h, want 1/0/1", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_all_request();
    logic [3:0] exp_d [4];
    exp_d[0] = 4'hA; exp_d[1] = 4'hB; exp_d[2] = 4'hC; exp_d[3] = 4'hD;
    do_reset();
    in_valid = 4'hF; out_ready = 1'b1;
    d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
    #1;
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (in_ready !== (4'b0001 << (c % 4))) begin
        n_bad++;
        $display("FAIL all_req_rdy cyc%0d: got %b, want %b", c, in_ready, 4'b0001 << (c % 4));
      end
      tick(); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_src !== 2'(c % 4) || out_data !== exp_d[c % 4]) begin
        n_bad++;
        $display("FAIL all_req_out cyc%0d: got v=%b s=%0d d=%h, want 1/%0d/%h",
                 c, out_valid, out_src, out_data, c % 4, exp_d[c % 4]);
      end
    end
  endtask

  task automatic test_single_channel();
    do_reset();
    in_valid = 4'b0100; d2 = 4'h7; out_ready = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (in_ready !== 4'b0100) begin
        n_bad++;
        $display("FAIL single_rdy cyc%0d: got %b, want 0100", c, in_ready);
      end
      tick(); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 4'h7) begin
        n_bad++;
        $display("FAIL single_out cyc%0d: got v=%b s=%0d d=%h, want 1/2/7", c, out_valid, out_src, out_data);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 4'b0010; d1 = 4'h5; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 4'hF;
    d0 = 4'h1; d1 = 4'h9; d2 = 4'hE; d3 = 4'h3;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (in_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL bp_rdy cyc%0d: got %b, want 0000", c, in_ready);
      end
      tick(); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 4'h5) begin
        n_bad++;
        $display("FAIL bp_hold cyc%0d: got v=%b s=%0d d=%h, want 1/1/5", c, out_valid, out_src, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL bp_release_rdy: got %b, want 0100", in_ready);
    end
    tick(); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 4'hE) begin
      n_bad++;
      $display("FAIL bp_release_out: got v=%b s=%0d d=%h, want 1/2/e", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    in_valid = 4'b0100; d2 = 4'h2; out_ready = 1'b1;
    tick();
    in_valid = 4'b0010; d1 = 4'h6;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL wrap_rdy: got %b, want 0010", in_ready);
    end
    tick(); #1;
    n_cmp++;
    if (out_src !== 2'd1 || out_data !== 4'h6) begin
      n_bad++;
      $display("FAIL wrap_out: got s=%0d d=%h, want 1/6", out_src, out_data);
    end
    in_valid = 4'hF;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL wrap_ptr2: got %b, want 0100", in_ready);
    end
    do_reset();
    in_valid = 4'b1001; d0 = 4'h9; d3 = 4'bxxxx;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL skip_rdy: got %b, want 0001", in_ready);
    end
    tick(); #1;
    n_cmp++;
    if (out_data !== 4'h9 || out_src !== 2'd0 || $isunknown(out_data)) begin
      n_bad++;
      $display("FAIL skip_x_out: got s=%0d d=%h, want 0/9", out_src, out_data);
    end
    d3 = 4'h0;
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    in_valid = 4'b0001; d0 = 4'h6; out_ready = 1'b0;
    tick(); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 4'h6) begin
      n_bad++;
      $display("FAIL mid_setup: got v=%b d=%h, want 1/6", out_valid, out_data);
    end
    in_valid = 4'b0000; rst = 1'b1;
    tick(); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_src !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b d=%h s=%0d, want 0/0/0", out_valid, out_data, out_src);
    end
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_no_deliver cyc%0d: got v=%b, want 0", c, out_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'h0; out_ready = 1'b0;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    test_reset();
    test_all_request();
    test_single_channel();
    test_backpressure();
    test_wrap_skip();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
